// File: rtl/counter_mon_pkg.sv
// counter_mon_pkg: shared relation encoding, FSM states and data width for the counter monitor
package counter_mon_pkg;
  localparam int DW = 32;
  typedef enum logic [1:0] {EQ = 2'd0, LT = 2'd1, GT = 2'd2} rel_t;
  typedef enum logic [1:0] {IDLE = 2'd0, S_LT = 2'd1, S_LTGT = 2'd2} state_t;
endpackage

// File: rtl/counter_monitor_if.sv
// counter_monitor_if: sample inputs and monitor results bundled between driver and monitor
interface counter_monitor_if
  import counter_mon_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ZZ_W  = 8
);
  logic             clear;
  logic             sample_en;
  logic [DW-1:0]    c1;
  logic [DW-1:0]    c2;
  rel_t             rel;
  logic [CNT_W-1:0] cross_cnt;
  logic             zigzag;
  logic [ZZ_W-1:0]  zz_cnt;
  logic [DW-1:0]    max_gap;
  modport master (output clear, sample_en, c1, c2, input rel, cross_cnt, zigzag, zz_cnt, max_gap);
  modport slave  (input clear, sample_en, c1, c2, output rel, cross_cnt, zigzag, zz_cnt, max_gap);
endinterface

// File: rtl/counter_rel_cmp.sv
// counter_rel_cmp: unsigned relation and absolute difference of two counter values
module counter_rel_cmp
  import counter_mon_pkg::*;
(
  input  logic [DW-1:0] c1_i,
  input  logic [DW-1:0] c2_i,
  output rel_t          rel_o,
  output logic [DW-1:0] gap_o
);
  assign rel_o = (c1_i < c2_i) ? LT : (c1_i > c2_i) ? GT : EQ;
  assign gap_o = (c1_i >= c2_i) ? c1_i - c2_i : c2_i - c1_i;
endmodule

// File: rtl/counter_monitor.sv
// counter_monitor: tracks relation, crossings, LT-GT-LT zigzags and peak gap of two counters
module counter_monitor
  import counter_mon_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ZZ_W  = 8
)(
  input logic              clk,
  input logic              rst,
  counter_monitor_if.slave bus
);
  rel_t             rel_n, rel_q, rel_d;
  logic [DW-1:0]    gap, max_q, max_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cross_q, cross_d;
  logic [ZZ_W-1:0]  zz_q, zz_d;
  logic             zig_q, zig_d, crossing, zig_hit;

  counter_rel_cmp u_cmp (.c1_i(bus.c1), .c2_i(bus.c2), .rel_o(rel_n), .gap_o(gap));

  always_comb begin
    crossing = (rel_q == LT && rel_n == GT) || (rel_q == GT && rel_n == LT);
    zig_hit  = state_q == S_LTGT && rel_n == LT;
    state_d  = state_q;
    rel_d    = rel_q;
    cross_d  = cross_q;
    zz_d     = zz_q;
    zig_d    = 1'b0;
    max_d    = max_q;
    if (bus.clear) begin
      state_d = IDLE;
      rel_d   = EQ;
      cross_d = '0;
      zz_d    = '0;
      max_d   = '0;
    end else if (bus.sample_en) begin
      rel_d   = rel_n;
      cross_d = (crossing && !(&cross_q)) ? cross_q + 1'b1 : cross_q;
      zz_d    = (zig_hit && !(&zz_q)) ? zz_q + 1'b1 : zz_q;
      zig_d   = zig_hit;
      max_d   = (gap > max_q) ? gap : max_q;
      // any LT restarts the pattern, so overlapping zigzags share their trailing LT
      state_d = (rel_n == LT) ? S_LT : (state_q == S_LT && rel_n == GT) ? S_LTGT : IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rel_q   <= EQ;
      cross_q <= '0;
      zz_q    <= '0;
      zig_q   <= 1'b0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      cross_q <= cross_d;
      zz_q    <= zz_d;
      zig_q   <= zig_d;
      max_q   <= max_d;
    end
  end

  assign bus.rel       = rel_q;
  assign bus.cross_cnt = cross_q;
  assign bus.zigzag    = zig_q;
  assign bus.zz_cnt    = zz_q;
  assign bus.max_gap   = max_q;
endmodule

// File: tb/tb_counter_monitor.sv
// tb_counter_monitor: random and directed stimulus checked against a sample-history reference model
module tb_counter_monitor;
  localparam int CNT_W = 16;
  localparam int ZZ_W  = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int ZMAX  = (1 << ZZ_W) - 1;
  localparam int R_EQ = 0, R_LT = 1, R_GT = 2;

  logic clk = 0;
  logic rst = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  counter_monitor_if #(.CNT_W(CNT_W), .ZZ_W(ZZ_W)) bus ();
  counter_monitor #(.CNT_W(CNT_W), .ZZ_W(ZZ_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // reference: last two sample relations, counters as plain integers
  int          m_rel, m_prev, m_cross, m_zz;
  logic        m_zig;
  logic [31:0] m_max;

  function automatic int rel_of(logic [31:0] a, logic [31:0] b);
    return (a < b) ? R_LT : (a > b) ? R_GT : R_EQ;
  endfunction

  function automatic logic [31:0] gap_of(logic [31:0] a, logic [31:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  function automatic bit is_cross(int p, int n);
    return (p == R_LT && n == R_GT) || (p == R_GT && n == R_LT);
  endfunction

  function automatic bit is_zig(int p2, int p1, int n);
    return p2 == R_LT && p1 == R_GT && n == R_LT;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || bus.clear) begin
      m_rel <= R_EQ; m_prev <= R_EQ; m_cross <= 0; m_zz <= 0; m_zig <= 0; m_max <= 0;
    end else if (bus.sample_en) begin
      m_cross <= (is_cross(m_rel, rel_of(bus.c1, bus.c2)) && m_cross < CMAX) ? m_cross + 1 : m_cross;
      m_zz    <= (is_zig(m_prev, m_rel, rel_of(bus.c1, bus.c2)) && m_zz < ZMAX) ? m_zz + 1 : m_zz;
      m_zig   <= is_zig(m_prev, m_rel, rel_of(bus.c1, bus.c2));
      m_max   <= (gap_of(bus.c1, bus.c2) > m_max) ? gap_of(bus.c1, bus.c2) : m_max;
      m_prev  <= m_rel;
      m_rel   <= rel_of(bus.c1, bus.c2);
    end else begin
      m_zig <= 0;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("rel", 32'(bus.rel), 32'(m_rel));
    chk("cross_cnt", 32'(bus.cross_cnt), 32'(m_cross));
    chk("zigzag", 32'(bus.zigzag), 32'(m_zig));
    chk("zz_cnt", 32'(bus.zz_cnt), 32'(m_zz));
    chk("max_gap", bus.max_gap, m_max);
  end

  task automatic sample(logic [31:0] a, logic [31:0] b);
    @(posedge clk); #2;
    bus.sample_en = 1; bus.c1 = a; bus.c2 = b;
    @(posedge clk); #2;
    bus.sample_en = 0;
  endtask

  task automatic clr();
    @(posedge clk); #2 bus.clear = 1;
    @(posedge clk); #2 bus.clear = 0;
  endtask

  task automatic lit(logic [1:0] r, int cr, logic z, int zz, logic [31:0] mx, string tag);
    chk({tag, ".rel"}, 32'(bus.rel), 32'(r));
    chk({tag, ".cross"}, 32'(bus.cross_cnt), 32'(cr));
    chk({tag, ".zig"}, 32'(bus.zigzag), 32'(z));
    chk({tag, ".zz"}, 32'(bus.zz_cnt), 32'(zz));
    chk({tag, ".max"}, bus.max_gap, mx);
  endtask

  initial begin
    bus.clear = 0; bus.sample_en = 0; bus.c1 = 0; bus.c2 = 0;
    #1 rst = 1;
    #20 lit(2'd0, 0, 0, 0, 0, "reset");
    @(posedge clk); #2 rst = 0;

    sample(1, 2); sample(5, 2); sample(3, 4);
    lit(2'd1, 2, 1, 1, 3, "zz1");
    sample(9, 4); sample(0, 4);
    lit(2'd1, 4, 1, 2, 5, "zz2");

    clr();
    sample(1, 2); sample(2, 2); sample(5, 2); sample(1, 2);
    lit(2'd1, 1, 0, 0, 3, "eqbreak");

    clr();
    sample(0, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    sample(32'hFFFF_FFFF, 0);
    lit(2'd2, 1, 0, 0, 32'hFFFF_FFFF, "wide");

    clr();
    sample(1, 2); sample(5, 2);
    #2 rst = 1;
    #1 lit(2'd0, 0, 0, 0, 0, "asyncrst");
    #2 rst = 0;
    sample(1, 2);
    lit(2'd1, 0, 0, 0, 1, "postrst");

    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      bus.clear     = $urandom_range(0, 49) == 0;
      bus.sample_en = $urandom_range(0, 9) < 7;
      bus.c1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      bus.c2 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
    end
    @(posedge clk); #2 bus.clear = 0; bus.sample_en = 0;

    clr();
    for (int i = 0; i < CMAX + 8; i++) begin
      @(posedge clk); #2;
      bus.sample_en = 1; bus.c1 = (i % 2 == 0) ? 1 : 2; bus.c2 = (i % 2 == 0) ? 2 : 1;
    end
    @(posedge clk); #2 bus.sample_en = 0;
    chk("sat.cross", 32'(bus.cross_cnt), 32'hFFFF);
    chk("sat.zz", 32'(bus.zz_cnt), 32'hFF);
    @(posedge clk); #2;
    bus.clear = 1; bus.sample_en = 1; bus.c1 = 0; bus.c2 = 9;
    @(posedge clk); #2 bus.clear = 0; bus.sample_en = 0;
    lit(2'd0, 0, 0, 0, 0, "clrsample");

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
